// File: rtl/control_unit.sv
// Multicycle MIPS-subset control sequencer: one state per clock, registered
// Moore outputs, invalid-opcode and overflow exceptions vectored via memory.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic [1:0] iord,
    output logic [1:0] error_sel,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic [2:0] regdst,
    output logic [3:0] memtoreg,
    output logic       reg_write,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       aluout_write,
    output logic       epc_write,
    output logic [2:0] pcsource,
    output logic       ls_byte,
    output logic [4:0] state_dbg
);

    typedef enum logic [4:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_R_ALU, S_R_WB, S_JR, S_ADDI, S_I_WB,
        S_MEMADR, S_LW0, S_LW1, S_LW2, S_LW3, S_SW0,
        S_BRANCH, S_J, S_JAL,
        S_EXC0, S_EXC1, S_EXC2, S_EXC3, S_EXC4
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] iord;
        logic [1:0] error_sel;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       ab_write;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic       reg_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       aluout_write;
        logic       epc_write;
        logic [2:0] pcsource;
        logic       ls_byte;
    } ctl_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;

    state_t state;
    state_t nxt;
    ctl_t   ctl;
    logic   code;
    logic   code_nxt;

    always_comb begin
        nxt      = state;
        code_nxt = code;
        case (state)
            S_RESET:  nxt = S_FETCH0;
            S_FETCH0: nxt = S_FETCH1;
            S_FETCH1: nxt = S_FETCH2;
            S_FETCH2: nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24: nxt = S_R_ALU;
                            6'h08:               nxt = S_JR;
                            default: begin
                                nxt      = S_EXC0;
                                code_nxt = 1'b0;
                            end
                        endcase
                    end
                    6'h08:        nxt = S_ADDI;
                    6'h23, 6'h2B: nxt = S_MEMADR;
                    6'h04, 6'h05: nxt = S_BRANCH;
                    6'h02:        nxt = S_J;
                    6'h03:        nxt = S_JAL;
                    default: begin
                        nxt      = S_EXC0;
                        code_nxt = 1'b0;
                    end
                endcase
            end
            S_R_ALU: begin
                if (alu_overflow && funct != 6'h24) begin
                    nxt      = S_EXC0;
                    code_nxt = 1'b1;
                end else begin
                    nxt = S_R_WB;
                end
            end
            S_ADDI: begin
                if (alu_overflow) begin
                    nxt      = S_EXC0;
                    code_nxt = 1'b1;
                end else begin
                    nxt = S_I_WB;
                end
            end
            S_MEMADR: nxt = opcode[3] ? S_SW0 : S_LW0;
            S_LW0:    nxt = S_LW1;
            S_LW1:    nxt = S_LW2;
            S_LW2:    nxt = S_LW3;
            S_EXC0:   nxt = S_EXC1;
            S_EXC1:   nxt = S_EXC2;
            S_EXC2:   nxt = S_EXC3;
            S_EXC3:   nxt = S_EXC4;
            default:  nxt = S_FETCH0;
        endcase
    end

    // Outputs are decoded from the state being entered, so they are registered
    function automatic ctl_t decode(state_t s, logic [5:0] fn, logic c);
        ctl_t d;
        d = '0;
        case (s)
            S_FETCH0, S_FETCH1: begin
                d.alusrcb = 2'd1;
                d.aluop   = OP_ADD;
            end
            S_FETCH2: begin
                d.alusrcb  = 2'd1;
                d.aluop    = OP_ADD;
                d.ir_write = 1'b1;
                d.pc_write = 1'b1;
            end
            S_DECODE: begin
                d.ab_write     = 1'b1;
                d.alusrcb      = 2'd3;
                d.aluop        = OP_ADD;
                d.aluout_write = 1'b1;
            end
            S_R_ALU: begin
                d.alusrca      = 1'b1;
                d.aluout_write = 1'b1;
                d.aluop        = (fn == 6'h22) ? OP_SUB :
                                 (fn == 6'h24) ? OP_AND : OP_ADD;
            end
            S_R_WB: begin
                d.regdst    = 3'd1;
                d.memtoreg  = 4'd1;
                d.reg_write = 1'b1;
            end
            S_ADDI, S_MEMADR: begin
                d.alusrca      = 1'b1;
                d.alusrcb      = 2'd2;
                d.aluop        = OP_ADD;
                d.aluout_write = 1'b1;
            end
            S_I_WB: begin
                d.memtoreg  = 4'd1;
                d.reg_write = 1'b1;
            end
            S_LW0, S_LW1: d.iord = 2'd2;
            S_LW2: begin
                d.iord      = 2'd2;
                d.mdr_write = 1'b1;
            end
            S_LW3: begin
                d.memtoreg  = 4'd4;
                d.reg_write = 1'b1;
            end
            S_SW0: begin
                d.iord      = 2'd2;
                d.mem_write = 1'b1;
            end
            S_BRANCH: begin
                d.alusrca  = 1'b1;
                d.aluop    = OP_SUB;
                d.pcsource = 3'd2;
            end
            S_J: begin
                d.pcsource = 3'd4;
                d.pc_write = 1'b1;
            end
            S_JAL: begin
                d.pcsource  = 3'd4;
                d.pc_write  = 1'b1;
                d.regdst    = 3'd2;
                d.memtoreg  = 4'd8;
                d.reg_write = 1'b1;
            end
            S_JR: begin
                d.pcsource = 3'd3;
                d.pc_write = 1'b1;
            end
            S_EXC0: begin
                d.alusrcb   = 2'd1;
                d.aluop     = OP_SUB;
                d.epc_write = 1'b1;
            end
            S_EXC1, S_EXC2: begin
                d.iord      = 2'd1;
                d.error_sel = {1'b0, c};
            end
            S_EXC3: begin
                d.iord      = 2'd1;
                d.error_sel = {1'b0, c};
                d.mdr_write = 1'b1;
            end
            S_EXC4: begin
                d.ls_byte  = 1'b1;
                d.pcsource = 3'd5;
                d.pc_write = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            ctl   <= '0;
            code  <= 1'b0;
        end else begin
            state <= nxt;
            ctl   <= decode(nxt, funct, code_nxt);
            code  <= code_nxt;
        end
    end

    // Branch decision is the one output that must see the live ALU flag
    assign pc_write = ctl.pc_write |
                      ((state == S_BRANCH) & (alu_zero ^ opcode[0]));

    assign iord         = ctl.iord;
    assign error_sel    = ctl.error_sel;
    assign mem_write    = ctl.mem_write;
    assign ir_write     = ctl.ir_write;
    assign mdr_write    = ctl.mdr_write;
    assign ab_write     = ctl.ab_write;
    assign regdst       = ctl.regdst;
    assign memtoreg     = ctl.memtoreg;
    assign reg_write    = ctl.reg_write;
    assign alusrca      = ctl.alusrca;
    assign alusrcb      = ctl.alusrcb;
    assign aluop        = ctl.aluop;
    assign aluout_write = ctl.aluout_write;
    assign epc_write    = ctl.epc_write;
    assign pcsource     = ctl.pcsource;
    assign ls_byte      = ctl.ls_byte;
    assign state_dbg    = state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected output sequences built
// from the instruction-class rules, compared cycle by cycle.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_overflow;
    logic       alu_zero;
    logic       pc_write;
    logic [1:0] iord;
    logic [1:0] error_sel;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic [2:0] regdst;
    logic [3:0] memtoreg;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       aluout_write;
    logic       epc_write;
    logic [2:0] pcsource;
    logic       ls_byte;
    logic [4:0] state_dbg;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .pc_write(pc_write), .iord(iord), .error_sel(error_sel),
        .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .ab_write(ab_write), .regdst(regdst),
        .memtoreg(memtoreg), .reg_write(reg_write), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .aluout_write(aluout_write),
        .epc_write(epc_write), .pcsource(pcsource), .ls_byte(ls_byte),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] iord;
        logic [1:0] error_sel;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       ab_write;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic       reg_write;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       aluout_write;
        logic       epc_write;
        logic [2:0] pcsource;
        logic       ls_byte;
    } exp_t;

    exp_t act;
    assign act = {pc_write, iord, error_sel, mem_write, ir_write,
                  mdr_write, ab_write, regdst, memtoreg, reg_write,
                  alusrca, alusrcb, aluop, aluout_write, epc_write,
                  pcsource, ls_byte};

    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];

    function automatic void push_exc(logic c);
        exp_t e;
        e = '0; e.alusrcb = 2'd1; e.aluop = 3'b010; e.epc_write = 1'b1;
        expq.push_back(e);
        e = '0; e.iord = 2'd1; e.error_sel = {1'b0, c};
        expq.push_back(e);
        expq.push_back(e);
        e.mdr_write = 1'b1;
        expq.push_back(e);
        e = '0; e.ls_byte = 1'b1; e.pcsource = 3'd5; e.pc_write = 1'b1;
        expq.push_back(e);
    endfunction

    // Expected per-cycle outputs of one instruction, FETCH0 onward
    function automatic void model(logic [5:0] op, logic [5:0] fn,
                                  logic ovf, logic zero);
        exp_t e;
        expq.delete();
        e = '0; e.alusrcb = 2'd1; e.aluop = 3'b001;
        expq.push_back(e);
        expq.push_back(e);
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        expq.push_back(e);
        e = '0; e.ab_write = 1'b1; e.alusrcb = 2'd3; e.aluop = 3'b001;
        e.aluout_write = 1'b1;
        expq.push_back(e);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            e = '0; e.alusrca = 1'b1; e.aluout_write = 1'b1;
            e.aluop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            expq.push_back(e);
            if (ovf && fn != 6'h24) push_exc(1'b1);
            else begin
                e = '0; e.regdst = 3'd1; e.memtoreg = 4'd1; e.reg_write = 1'b1;
                expq.push_back(e);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            e = '0; e.pcsource = 3'd3; e.pc_write = 1'b1;
            expq.push_back(e);
        end else if (op == 6'h08) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'd2; e.aluop = 3'b001;
            e.aluout_write = 1'b1;
            expq.push_back(e);
            if (ovf) push_exc(1'b1);
            else begin
                e = '0; e.memtoreg = 4'd1; e.reg_write = 1'b1;
                expq.push_back(e);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'd2; e.aluop = 3'b001;
            e.aluout_write = 1'b1;
            expq.push_back(e);
            e = '0; e.iord = 2'd2;
            if (op == 6'h23) begin
                expq.push_back(e);
                expq.push_back(e);
                e.mdr_write = 1'b1;
                expq.push_back(e);
                e = '0; e.memtoreg = 4'd4; e.reg_write = 1'b1;
                expq.push_back(e);
            end else begin
                e.mem_write = 1'b1;
                expq.push_back(e);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            e = '0; e.alusrca = 1'b1; e.aluop = 3'b010; e.pcsource = 3'd2;
            e.pc_write = (op == 6'h04) ? zero : !zero;
            expq.push_back(e);
        end else if (op == 6'h02 || op == 6'h03) begin
            e = '0; e.pcsource = 3'd4; e.pc_write = 1'b1;
            if (op == 6'h03) begin
                e.regdst = 3'd2; e.memtoreg = 4'd8; e.reg_write = 1'b1;
            end
            expq.push_back(e);
        end else begin
            push_exc(1'b0);
        end
    endfunction

    // Entered at a falling edge while the DUT sits in FETCH0
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic zero);
        opcode = op; funct = fn; alu_overflow = ovf; alu_zero = zero;
        model(op, fn, ovf, zero);
        for (int i = 0; i < expq.size(); i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (act !== expq[i]) begin
                fails++;
                $display("FAIL instr op=%h fn=%h ovf=%b z=%b cyc=%0d got=%h want=%h",
                         op, fn, ovf, zero, i, act, expq[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = '0; funct = '0;
        alu_overflow = 1'b0; alu_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (act !== '0) begin
                fails++;
                $display("FAIL reset_outputs got=%h want=0", act);
            end
        end
        rst = 1'b0;
        model(6'h00, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (act !== expq[0]) begin
            fails++;
            $display("FAIL reset_to_fetch0 got=%h want=%h", act, expq[0]);
        end
    endtask

    task automatic test_alu();
        run_instr(6'h00, 6'h20, 1'b0, 1'b0);
        run_instr(6'h00, 6'h22, 1'b0, 1'b1);
        run_instr(6'h00, 6'h24, 1'b1, 1'b0);
        run_instr(6'h08, 6'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic test_load_store();
        run_instr(6'h23, 6'($urandom), 1'($urandom), 1'($urandom));
        run_instr(6'h2B, 6'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'($urandom), 1'b0, 1'b1);
        run_instr(6'h04, 6'($urandom), 1'b0, 1'b0);
        run_instr(6'h05, 6'($urandom), 1'b0, 1'b1);
        run_instr(6'h05, 6'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_jumps();
        run_instr(6'h02, 6'($urandom), 1'b0, 1'b0);
        run_instr(6'h03, 6'($urandom), 1'b0, 1'b0);
        run_instr(6'h00, 6'h08, 1'b0, 1'b0);
    endtask

    task automatic test_exceptions();
        run_instr(6'h08, 6'($urandom), 1'b1, 1'b0);
        run_instr(6'h00, 6'h20, 1'b1, 1'b0);
        run_instr(6'h00, 6'h22, 1'b1, 1'b1);
        run_instr(6'h3F, 6'($urandom), 1'b0, 1'b0);
        run_instr(6'h00, 6'h2A, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] ops [12];
        logic [5:0] fns [6];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B,
                6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h2A, 6'h00};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(11)];
            if ($urandom_range(7) == 0) op = 6'($urandom);
            fn = (op == 6'h00) ? fns[$urandom_range(4)] : 6'($urandom);
            if (op == 6'h00 && $urandom_range(7) == 0) fn = 6'($urandom);
            run_instr(op, fn, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_mid_reset();
        opcode = 6'h23; funct = '0; alu_overflow = 1'b0; alu_zero = 1'b1;
        model(6'h23, 6'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (act !== expq[i]) begin
                fails++;
                $display("FAIL midrst_lw cyc=%0d got=%h want=%h", i, act, expq[i]);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (act !== '0) begin
                fails++;
                $display("FAIL midrst_zero cyc=%0d got=%h want=0", i, act);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge clk);
            tests++;
            if (act !== expq[i]) begin
                fails++;
                $display("FAIL midrst_restart cyc=%0d got=%h want=%h",
                         i, act, expq[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (act !== expq[0]) begin
            fails++;
            $display("FAIL midrst_next_fetch got=%h want=%h", act, expq[0]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps();
        test_exceptions();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
